mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 DIVU, 01 DIV, 10 MULTU, 11 MULT.
REQ-006 SHALL have port a  input  32  dividend or multiplicand.
REQ-007 SHALL have port b  input  32  divisor or multiplier.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  single-cycle pulse when hi/lo are updated.
REQ-010 SHALL have port hi  output  32  remainder (DIV/DIVU) or upper product (MULT/MULTU).
REQ-011 SHALL have port lo  output  32  quotient (DIV/DIVU) or lower product (MULT/MULTU).
REQ-012 SHALL have port div_zero  output  1  sticky flag from the last divide; cleared on the next accepted start.

Function
REQ-013 SHALL use states IDLE, RUN, FIX and DONE.
REQ-014 In IDLE, start=1 SHALL:
- latch op, |a| and |b| (signed ops) or raw values;
- latch the result-sign and remainder-sign bits;
- clear the iteration counter;
- go to RUN.
REQ-015 In RUN, each cycle SHALL perform one radix-2 step: restoring divide or shift-add multiply. After exactly 32 steps the state SHALL go to FIX.
REQ-016 In FIX, signed ops SHALL apply sign correction:
- quotient is negative iff the operand signs differ;
- remainder takes the sign of the dividend;
- product is negated iff the operand signs differ.
The state SHALL then go to DONE.
REQ-017 In DONE, done=1 for one cycle, hi/lo SHALL be written, and the state SHALL return to IDLE.
REQ-018 Latency: done SHALL be high exactly 35 cycles after the start cycle (1 accept + 32 RUN + 1 FIX + 1 DONE).
REQ-019 Back-to-back: a start in the cycle following done SHALL be accepted.
REQ-020 start while busy=1 SHALL be ignored, with no effect on state, operands or results.
REQ-021 Divide with b=0 SHALL skip RUN and FIX and go straight to DONE. It SHALL set lo=32'hFFFF_FFFF, hi=a and div_zero=1.
REQ-022 DIV 0x8000_0000 / 0xFFFF_FFFF SHALL yield lo=0x8000_0000, hi=0, with no flag.
REQ-023 hi and lo SHALL hold their values between operations and change only in DONE.
REQ-024 Arithmetic SHALL use a 33-bit partial remainder for divide and a 64-bit accumulator for multiply, with no truncation before FIX.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE and set busy=0, done=0, hi=0, lo=0, div_zero=0 and counter=0.
REQ-026 Reset during RUN or FIX SHALL abort the operation with no done pulse; hi/lo SHALL read 0 afterwards.

Configuration
REQ-027 The macro MUL_DIV_UNIT_MULT_EN SHALL compile the multiply datapath in.
REQ-028 Without MUL_DIV_UNIT_MULT_EN, op[1]=1 SHALL be treated as illegal:
- skip RUN and FIX;
- pulse done 2 cycles after start;
- leave hi, lo and div_zero unchanged.

Structure
REQ-029 A shared package mdu_pkg SHALL hold:
- the op encodings (OP_DIVU, OP_DIV, OP_MULTU, OP_MULT);
- the state enum;
- the ITER=32 constant.
REQ-030 The iterative datapath SHALL be the sub-module mdu_core. It holds the remainder/accumulator registers and the step logic; mul_div_unit holds the FSM, counter and result registers.

Verification
REQ-031 DIVU a=100 b=7 -> lo=14, hi=2, done 35 cycles after start, busy high for cycles 1-34.
REQ-032 DIV a=-7 b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIV a=7 b=-2 -> lo=0xFFFF_FFFD, hi=1.
REQ-033 DIVU a=5 b=0 -> lo=0xFFFF_FFFF, hi=5, div_zero=1, done 2 cycles after start; the next start clears div_zero.
REQ-034 DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0; a second start pulsed at cycle 10 is ignored and the first result is unchanged.
REQ-035 Reset asserted at RUN cycle 16 -> no done pulse, hi=lo=0, next start completes normally.
REQ-036 With MUL_DIV_UNIT_MULT_EN: MULTU 0xFFFF_FFFF*2 -> hi=1, lo=0xFFFF_FFFE; MULT -3*5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. Without the macro, the same ops produce done with hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and iteration count for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned ITER = 32;
  localparam int unsigned CntW = 6;

  localparam logic [1:0] OP_DIVU  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_MULT  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative radix-2 datapath: restoring divide and (with MUL_DIV_UNIT_MULT_EN) shift-add multiply.
module mdu_core #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic             mul_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  // rem_q/quo_q double as the upper/lower halves of the product accumulator.
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] dvs_q, dvs_d;
  logic [Width:0]   part;
  logic [Width:0]   diff;

`ifdef MUL_DIV_UNIT_MULT_EN
  logic [Width:0]   sum;
`else
  logic             unused_mul;
  assign unused_mul = mul_i;
`endif

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    part  = {rem_q, quo_q[Width-1]};
    diff  = part - {1'b0, dvs_q};
`ifdef MUL_DIV_UNIT_MULT_EN
    sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
`endif
    if (load_i) begin
      rem_d = '0;
      quo_d = a_i;
      dvs_d = b_i;
    end else if (step_i) begin
`ifdef MUL_DIV_UNIT_MULT_EN
      if (mul_i) begin
        rem_d = sum[Width:1];
        quo_d = {sum[0], quo_q[Width-1:1]};
      end else
`endif
      if (!diff[Width]) begin
        rem_d = diff[Width-1:0];
        quo_d = {quo_q[Width-2:0], 1'b1};
      end else begin
        rem_d = part[Width-1:0];
        quo_d = {quo_q[Width-2:0], 1'b0};
      end
    end else if (fix_i) begin
`ifdef MUL_DIV_UNIT_MULT_EN
      if (mul_i) begin
        if (neg_lo_i) {rem_d, quo_d} = -{rem_q, quo_q};
      end else
`endif
      begin
        if (neg_hi_i) rem_d = -rem_q;
        if (neg_lo_i) quo_d = -quo_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign hi_o = rem_q;
  assign lo_o = quo_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: FSM, iteration counter and result registers.
// Multiply datapath is compiled in only when MUL_DIV_UNIT_MULT_EN is defined.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              bz_q, bz_d;
  logic              ill_q, ill_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              a_neg, b_neg, b_zero, illegal;
  logic              load, step, fix;
  logic [WIDTH-1:0]  core_a, core_b, core_hi, core_lo;

  // op[0] marks the signed variants of both divide and multiply.
  assign a_neg  = op[0] & a[WIDTH-1];
  assign b_neg  = op[0] & b[WIDTH-1];
  assign b_zero = !op[1] && (b == '0);
`ifdef MUL_DIV_UNIT_MULT_EN
  assign illegal = 1'b0;
`else
  assign illegal = op[1];
`endif

  // A zero divisor passes the raw dividend through so it can be returned unchanged.
  assign core_a = b_zero ? a : mag32(a, a_neg);
  assign core_b = mag32(b, b_neg);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          op_d    = op;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bz_d    = b_zero;
          ill_d   = illegal;
          cnt_d   = '0;
          if (!illegal) dz_d = 1'b0;
          state_d = (b_zero || illegal) ? StDone : StRun;
        end
      end
      StRun: begin
        step  = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) state_d = StFix;
      end
      StFix: begin
        fix     = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (!ill_q) begin
          if (bz_q) begin
            hi_d = core_lo;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = core_hi;
            lo_d = core_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OP_DIVU;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mdu_core #(
    .Width (WIDTH)
  ) u_core (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (load),
    .step_i   (step),
    .fix_i    (fix),
    .mul_i    (op_q[1]),
    .neg_hi_i (op_q[0] & rneg_q),
    .neg_lo_i (op_q[0] & qneg_q),
    .a_i      (core_a),
    .b_i      (core_b),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit; honours MUL_DIV_UNIT_MULT_EN the same way as the design.
module tb_mul_div_unit;

`ifdef MUL_DIV_UNIT_MULT_EN
  localparam bit MultEn = 1'b1;
`else
  localparam bit MultEn = 1'b0;
`endif

  localparam logic [1:0] DIVU  = 2'b00;
  localparam logic [1:0] DIV   = 2'b01;
  localparam logic [1:0] MULTU = 2'b10;
  localparam logic [1:0] MULT  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Reference arithmetic; keeps its own copy of the architectural result state.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, p;
    longint unsigned up;
    e.hi = m_hi; e.lo = m_lo; e.dz = m_dz; e.lat = 35;
    if (o[1]) begin
      if (!MultEn) begin
        e.lat = 2;
      end else begin
        e.dz = 1'b0;
        if (o[0]) begin
          p = longint'($signed(x)) * longint'($signed(y));
          {e.hi, e.lo} = p;
        end else begin
          up = {32'b0, x} * {32'b0, y};
          {e.hi, e.lo} = up;
        end
      end
    end else if (y == 32'd0) begin
      e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 2;
    end else begin
      e.dz = 1'b0;
      if (o[0]) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.lo = 32'(sx / sy);
        e.hi = 32'(sx % sy);
      end else begin
        e.lo = x / y;
        e.hi = x % y;
      end
    end
    m_hi = e.hi; m_lo = e.lo; m_dz = e.dz;
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle k is the k-th cycle after the edge that accepted start.
  task automatic wait_done(input int skip, output int lat, output int bcnt, output bit to);
    lat = 0; bcnt = 0; to = 1'b1;
    for (int i = skip + 1; i <= skip + 100; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero",
               busy, done, div_zero, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu();
    exp_t e; int lat, bc; bit to;
    issue(DIVU, 32'd100, 32'd7);
    wait_done(0, lat, bc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != e.lat) begin
      n_fail++; $display("FAIL divu_latency: got %0d (timeout=%0b) required %0d", lat, to, e.lat);
    end
    n_checks++;
    if (bc != 34) begin
      n_fail++; $display("FAIL divu_busy_cycles: got %0d required 34", bc);
    end
    n_checks++;
    if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      n_fail++;
      $display("FAIL divu_result: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
               hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] xa[2] = '{32'hFFFF_FFF9, 32'd7};
    logic [31:0] xb[2] = '{32'd2, 32'hFFFF_FFFE};
    logic [31:0] req_hi[2] = '{32'hFFFF_FFFF, 32'd1};
    exp_t e; int lat, bc; bit to;
    for (int i = 0; i < 2; i++) begin
      issue(DIV, xa[i], xb[i]);
      wait_done(0, lat, bc, to);
      e = sb.pop_front();
      n_checks++;
      if (to || lat != 35) begin
        n_fail++; $display("FAIL div_signed_latency[%0d]: got %0d required 35", i, lat);
      end
      n_checks++;
      if (hi !== req_hi[i] || lo !== 32'hFFFF_FFFD || hi !== e.hi || lo !== e.lo) begin
        n_fail++;
        $display("FAIL div_signed_result[%0d]: hi=%h lo=%h required hi=%h lo=fffffffd",
                 i, hi, lo, req_hi[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e; int lat, bc; bit to;
    issue(DIVU, 32'd5, 32'd0);
    wait_done(0, lat, bc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 2) begin
      n_fail++; $display("FAIL div_zero_latency: got %0d required 2", lat);
    end
    n_checks++;
    if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_result: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=1",
               hi, lo, div_zero, e.hi, e.lo);
    end
    issue(DIVU, 32'd9, 32'd3);
    @(negedge clk);
    n_checks++;
    if (div_zero !== 1'b0) begin
      n_fail++; $display("FAIL div_zero_clear: dz=%b required 0", div_zero);
    end
    wait_done(1, lat, bc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 35 || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL div_after_zero: lat=%0d hi=%h lo=%h required lat=35 hi=%h lo=%h",
               lat, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_ignore_busy();
    exp_t e; int lat, bc, extra; bit to;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = m_hi; prev_lo = m_lo;
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    n_checks++;
    if (hi !== prev_hi || lo !== prev_lo) begin
      n_fail++;
      $display("FAIL hold_while_busy: hi=%h lo=%h required hi=%h lo=%h", hi, lo, prev_hi, prev_lo);
    end
    start = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, lat, bc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 35) begin
      n_fail++; $display("FAIL overflow_latency: got %0d required 35", lat);
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000 || div_zero !== 1'b0 || lo !== e.lo) begin
      n_fail++;
      $display("FAIL overflow_result: hi=%h lo=%h dz=%b required hi=0 lo=80000000 dz=0",
               hi, lo, div_zero);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0 || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL ignored_start: extra_done=%0d hi=%h lo=%h required 0 %h %h",
               extra, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e; int lat, bc, dones; bit to;
    issue(DIVU, 32'd1000, 32'd3);
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    void'(sb.pop_front());
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0 || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: dones=%0d hi=%h lo=%h busy=%b required 0 0 0 0",
               dones, hi, lo, busy);
    end
    issue(DIVU, 32'd1000, 32'd3);
    wait_done(0, lat, bc, to);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 35 || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL after_abort: lat=%0d hi=%h lo=%h required lat=35 hi=%h lo=%h",
               lat, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_mult();
    logic [1:0]  xo[2] = '{MULTU, MULT};
    logic [31:0] xa[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic [31:0] xb[2] = '{32'd2, 32'd5};
    exp_t e; int lat, bc; bit to;
    for (int i = 0; i < 2; i++) begin
      issue(xo[i], xa[i], xb[i]);
      wait_done(0, lat, bc, to);
      e = sb.pop_front();
      n_checks++;
      if (to || lat != e.lat) begin
        n_fail++; $display("FAIL mult_latency[%0d]: got %0d required %0d", i, lat, e.lat);
      end
      n_checks++;
      if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
        n_fail++;
        $display("FAIL mult_result[%0d]: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                 i, hi, lo, div_zero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat, bc; bit to;
    logic [1:0]  o;
    logic [31:0] x, y;
    issue(DIVU, 32'hFFFF_FFFF, 32'h10);
    for (int i = 0; i < 6; i++) begin
      wait_done(0, lat, bc, to);
      e = sb.pop_front();
      n_checks++;
      if (to || lat != e.lat || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: lat=%0d hi=%h lo=%h dz=%b required lat=%0d hi=%h lo=%h dz=%b",
                 i, lat, hi, lo, div_zero, e.lat, e.hi, e.lo, e.dz);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL done_pulse_width[%0d]: done=%b required 0", i, done);
      end
      if (i < 5) begin
        o = 2'($urandom_range(0, 1));
        x = $urandom;
        y = (i == 2) ? 32'hFFFF_FFF0 : 32'($urandom_range(1, 65535));
        issue(o, x, y);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_ignore_busy();
    test_reset_abort();
    test_mult();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
